// File: rtl/tx_char_scheduler.sv
// Arbitrates two byte requesters onto one transmit core, one character at a time, with a
// programmable guard gap. Define TX_CHAR_SCHEDULER_ROUND_ROBIN_EN for round-robin arbitration.
`timescale 1ns/1ps
module tx_char_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int GUARD_WIDTH  = 16,
  parameter int LOAD_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0Valid,
  input  logic [DATA_WIDTH-1:0]  req0Data,
  output logic                   req0Ready,
  input  logic                   req1Valid,
  input  logic [DATA_WIDTH-1:0]  req1Data,
  output logic                   req1Ready,
  input  logic [GUARD_WIDTH-1:0] guardCycles,
  output logic [DATA_WIDTH-1:0]  txData,
  output logic                   txLoad,
  input  logic                   txFull,
  input  logic                   txRun,
  output logic                   busy,
  output logic                   lastGrant,
  output logic                   timeoutErr,
  output logic [15:0]            charCount
);

  localparam int LCW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_DONE, S_GUARD} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   load_q, load_d;
  logic                   busy_q, busy_d;
  logic                   gnt_q, gnt_d;
  logic                   to_q, to_d;
  logic [15:0]            charCount_q, charCount_d;
  logic [LCW-1:0]         loadCnt_q, loadCnt_d;
  logic [GUARD_WIDTH-1:0] guard_q, guard_d;
  logic                   anyValid, grantSel, grantOk;

  assign anyValid = req0Valid | req1Valid;

`ifdef TX_CHAR_SCHEDULER_ROUND_ROBIN_EN
  // Contention goes to whoever did not win last; a lone valid always wins.
  assign grantSel = (req0Valid && req1Valid) ? ~gnt_q : ~req0Valid;
`else
  assign grantSel = ~req0Valid;
`endif

  // Ready is combinational, so reset must gate it directly.
  assign grantOk   = (state_q == S_IDLE) && !reset && anyValid;
  assign req0Ready = grantOk && !grantSel;
  assign req1Ready = grantOk && grantSel;

  assign txData     = data_q;
  assign txLoad     = load_q;
  assign busy       = busy_q;
  assign lastGrant  = gnt_q;
  assign timeoutErr = to_q;
  assign charCount  = charCount_q;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    load_d      = load_q;
    gnt_d       = gnt_q;
    to_d        = 1'b0;
    charCount_d = charCount_q;
    loadCnt_d   = loadCnt_q;
    guard_d     = guard_q;
    case (state_q)
      S_IDLE: begin
        if (anyValid) begin
          data_d    = grantSel ? req1Data : req0Data;
          gnt_d     = grantSel;
          load_d    = 1'b1;
          loadCnt_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (txFull) begin
          load_d      = 1'b0;
          charCount_d = charCount_q + 16'd1;
          state_d     = S_WAIT_DONE;
        end else if (loadCnt_q == LOAD_LAST) begin
          load_d  = 1'b0;
          to_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          loadCnt_d = loadCnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!txFull && !txRun) begin
          if (guardCycles == '0) begin
            state_d = S_IDLE;
          end else begin
            guard_d = guardCycles;
            state_d = S_GUARD;
          end
        end
      end
      S_GUARD: begin
        if (guard_q <= GUARD_WIDTH'(1)) state_d = S_IDLE;
        else guard_d = guard_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      gnt_q       <= 1'b1;
      to_q        <= 1'b0;
      charCount_q <= '0;
      loadCnt_q   <= '0;
      guard_q     <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      gnt_q       <= gnt_d;
      to_q        <= to_d;
      charCount_q <= charCount_d;
      loadCnt_q   <= loadCnt_d;
      guard_q     <= guard_d;
    end
  end

endmodule

// File: doc/tx_char_scheduler.md
# tx_char_scheduler

Shares one UART/ISO7816 transmit core between two byte requesters and sequences it one character at a time. It arbitrates the requesters, drives the core's data/load handshake, and waits for the character to finish. It then enforces a programmable extra guard time before the next character. It sits between the protocol layer (requester 0: command path, requester 1: retransmit/ack path) and the transmit core.

## Interface
- DATA_WIDTH, 8, character width.
- GUARD_WIDTH, 16, width of the guard-time count.
- LOAD_TIMEOUT, 1024, cycles in LOAD without the core accepting before the character is abandoned.
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0Valid, req1Valid  input  1  requester has a character.
- req0Data, req1Data  input  DATA_WIDTH  character.
- req0Ready, req1Ready  output  1  combinational accept strobe; transfer occurs on a clock edge where valid&&ready.
- guardCycles  input  GUARD_WIDTH  idle cycles inserted after each character. It is sampled when GUARD is entered.
- txData  output  DATA_WIDTH  to core dataIn.
- txLoad  output  1  to core loadDataIn.
- txFull  input  1  from core full.
- txRun  input  1  from core run.
- busy  output  1  state != IDLE.
- lastGrant  output  1  index of the most recently accepted requester.
- timeoutErr  output  1  one-cycle pulse on load timeout.
- charCount  output  16  characters accepted by the core, wraps 0xFFFF->0.

## Operation
- The state machine has four states: IDLE, LOAD, WAIT_DONE and GUARD.
- **IDLE**
  - If any valid is high, grant one requester by arbitration. Its ready is high combinationally.
  - On the edge, capture its data into txData, set lastGrant and go to LOAD.
  - Ready is never high outside IDLE and never high for both requesters.
- **LOAD**
  - txLoad=1, txData held stable.
  - When txFull==1 is sampled: txLoad<=0, charCount<=charCount+1, go to WAIT_DONE.
  - The load counter starts at 0 on LOAD entry. If it reaches LOAD_TIMEOUT-1 with txFull still 0: txLoad<=0, timeoutErr pulses for one cycle, go to IDLE. No guard time is applied and charCount is unchanged.
- **WAIT_DONE**
  - Wait until txFull==0 && txRun==0 are sampled together.
  - Then: if guardCycles==0 go to IDLE, else load the guard counter with guardCycles and go to GUARD.
- **GUARD**
  - Decrement the guard counter each cycle; when it equals 1, go to IDLE.
  - The effective gap is exactly guardCycles cycles spent in GUARD.
- Valid dropping while not granted has no effect. Data is captured only at acceptance, so the requester may change it afterwards.
- Reset mid-operation forces IDLE immediately (asynchronous). txLoad drops at once and the in-flight character is abandoned.

## Timing
- Reset values:
  - txLoad=0, txData=0, busy=0, lastGrant=1 (so requester 0 wins first under round-robin), timeoutErr=0, charCount=0.
  - req0Ready=req1Ready=0: both are gated by reset.
- Latency:
  - Acceptance at edge N gives txLoad=1 during cycle N+1.
  - txFull sampled high at edge M gives txLoad=0 from M+1.
- Minimum spacing between two acceptances is 3 cycles plus guardCycles plus the core's character time.
- busy is registered and follows state.
- timeoutErr is registered and high for exactly one cycle.

## Configuration
- TX_CHAR_SCHEDULER_ROUND_ROBIN_EN:
  - Defined: when both valids are high, grant the requester other than lastGrant. A single valid is always granted.
  - Undefined: fixed priority, requester 0 always wins. lastGrant is still updated.

## Test plan
- **Single character:** reset, guardCycles=4, req0Valid with 0x80; model core raises full 2 cycles after txLoad and drops full/run 50 cycles later.
  - txLoad is high from the acceptance edge+1 until full is seen, and txData=0x80.
  - busy is high for the full character plus exactly 4 GUARD cycles; charCount=1.
- **Contention:** both valids held with 0x11/0x22, guardCycles=0.
  - With macro: grants alternate 0,1,0,1 and txData follows 0x11,0x22,...
  - Without macro: only requester 0 is granted while its valid stays high.
- **Timeout:** txFull tied 0, LOAD_TIMEOUT=16.
  - txLoad is high for exactly 16 cycles, then timeoutErr pulses once, the block returns to IDLE and charCount=0.
- **Wrap:** preload by running 65536 characters (or force charCount=0xFFFF); the next accepted character gives charCount=0.
- **Reset mid-LOAD and mid-GUARD:** assert reset asynchronously between clock edges.
  - txLoad, busy and ready fall without a clock edge.
  - After release, the first valid is accepted in IDLE with no residual guard time.
- **Zero guard and back-to-back:** guardCycles=0, req1Valid held high.
  - The next acceptance occurs on the cycle immediately after WAIT_DONE sees full=0 and run=0.
